alarm_ringer: RTL and testbench
===============================

# alarm_ringer

Alarm sounding controller downstream of the clock/alarm top level. It consumes the alarm-time-match indication, the 1 s tick and the debounced Snooze/Stop buttons, and drives the buzzer. The buzzer sounds with a 1:1 beep pattern and supports a bounded number of snoozes. Ringing auto-silences after a timeout so an unattended alarm stops by itself.

## Interface
Parameters:
- BEEP_DIV, 25_000_000: masCLK cycles per buzzer half-period (2 Hz beep at 100 MHz).
- SNOOZE_S, 300: snooze duration in seconds.
- TIMEOUT_S, 60: maximum continuous ring time in seconds.
- MAX_SNOOZE, 3: snoozes allowed per alarm event (1..15).

Ports:
- masCLK  in  1  system clock, sole clock.
- Reset  in  1  **synchronous, active-high** reset.
- tick_1s  in  1  one-cycle pulse, once per second, synchronous to masCLK.
- match  in  1  level; high while alarm hour:min equals current hour:min.
- Alarm_ON  in  1  alarm enable level.
- Snooze_in  in  1  debounced snooze button level.
- Stop_in  in  1  debounced stop button level.
- Buzzer  out  1  beep drive.
- ringing  out  1  high in RING.
- snoozed  out  1  high in SNOOZE.
- snooze_cnt  out  4  snoozes used in the current event.

## Operation
- Buttons are rising-edge detected internally; the previous-value register resets to 0. A held button acts once.
- States: IDLE, RING, SNOOZE, DONE.
- **IDLE:** `Alarm_ON & match` -> RING. On entry to RING, clear ring_sec and the beep divider, and set Buzzer=1.
- **RING:**
  - ring_sec increments on each tick_1s.
  - Stop edge -> DONE.
  - Snooze edge with snooze_cnt < MAX_SNOOZE -> SNOOZE. snooze_cnt+1, load snz_left = SNOOZE_S.
  - Snooze edge with snooze_cnt == MAX_SNOOZE is ignored; the alarm keeps ringing.
  - tick_1s with ring_sec == TIMEOUT_S-1 -> DONE.
- **SNOOZE:**
  - snz_left decrements on tick_1s.
  - tick_1s with snz_left == 1 -> RING, using the same entry actions as above.
  - Stop edge -> DONE.
  - Snooze edge is ignored.
- **DONE:** wait for match == 0, then -> IDLE and clear snooze_cnt.
- **Priority within a cycle:** Reset > Alarm_ON low (from RING or SNOOZE -> DONE) > Stop > Snooze > tick-driven transitions.
- Alarm_ON low in IDLE or DONE has no effect. DONE still waits for match to drop, which prevents re-triggering within the same minute.
- **Buzzer:**
  - In RING, Buzzer toggles whenever the divider reaches BEEP_DIV-1; the divider then wraps to 0.
  - Buzzer is 0 in every other state.
- **Widths:**
  - ring_sec is $clog2(TIMEOUT_S+1) bits.
  - snz_left is $clog2(SNOOZE_S+1) bits.
  - divider is $clog2(BEEP_DIV) bits.
  - No counter wraps: each is bounded by its state exit.

## Timing
- All outputs are registered.
- Reset values: state=IDLE, Buzzer=0, ringing=0, snoozed=0, snooze_cnt=0, all counters 0.
- **Alarm start:** match and Alarm_ON both high on cycle N means state=RING, ringing=1 and Buzzer=1 on cycle N+1.
- **Button latency:** a button rising edge sampled on cycle N changes state on cycle N+2 (one cycle for the edge register, one for the state register).
- **Timeout:** ringing lasts exactly TIMEOUT_S tick_1s pulses after entry. The state leaves RING in the cycle after the TIMEOUT_S-th tick.
- **Snooze duration:** exactly SNOOZE_S ticks after entry to SNOOZE.
- **Simultaneous events:** a tick that coincides with a Stop edge resolves to DONE. A Snooze edge that coincides with the timeout tick resolves to SNOOZE.
- **Reset mid-operation:** at the next edge the block returns to IDLE with everything cleared. If match is still high and Alarm_ON is set, it re-enters RING one cycle later.

## Structure
- Shared package alarm_pkg holds:
  - the state enum (IDLE, RING, SNOOZE, DONE), 2 bits;
  - the snooze_cnt width constant (4).
- Sub-module edge_rise (masCLK, Reset, level in, one-cycle pulse out). It is instantiated twice, once for Snooze and once for Stop.
- All other logic is a single FSM plus counters in alarm_ringer.

## Test plan
Test parameters: BEEP_DIV=4, SNOOZE_S=5, TIMEOUT_S=3, MAX_SNOOZE=2, tick_1s every 20 cycles.

- **Start and beep pattern:** Alarm_ON=1, raise match -> ringing=1 next cycle. Buzzer pattern is 1,1,1,1,0,0,0,0 repeating.
- **Timeout:** no buttons pressed -> DONE after the 3rd tick, Buzzer=0. Dropping match -> IDLE. Re-raising match -> ringing again.
- **Snooze limit:**
  - Snooze edge in RING -> snoozed=1, snooze_cnt=1.
  - 5 ticks later -> ringing=1.
  - Second snooze -> snooze_cnt=2.
  - Third snooze edge in RING is ignored; ringing stays 1.
- **Stop and re-trigger guard:** Stop during SNOOZE -> DONE. Holding match=1 keeps the block in DONE with no re-ring. match=0 -> IDLE, snooze_cnt=0.
- **Priority and disable:** Stop and Snooze edges in the same cycle -> DONE. Alarm_ON dropped in RING -> DONE, Buzzer=0 on the next cycle.
- **Reset mid-ring:** Reset pulse during RING -> all outputs 0 at the next edge. With match and Alarm_ON still high -> RING one cycle after Reset is released.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types for the alarm sounding controller.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2,
    DONE   = 2'd3
  } alarm_state_e;

  localparam int SNZ_CNT_W = 4;

endpackage

// File: rtl/alarm_ringer_edge_rise.sv
// Registered rising-edge detector: a level rising on cycle N gives a one-cycle pulse on N+1.
module edge_rise (
  input  logic masCLK,
  input  logic Reset,
  input  logic level,
  output logic pulse
);

  logic prev;

  always_ff @(posedge masCLK) begin
    if (Reset) begin
      prev  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      prev  <= level;
      pulse <= level & ~prev;
    end
  end

endmodule

// File: rtl/alarm_ringer.sv
// Alarm sounding FSM: rings with a 1:1 beep, allows a bounded number of snoozes,
// auto-silences after a timeout and waits for the minute match to clear before re-arming.
module alarm_ringer
  import alarm_pkg::*;
#(
  parameter int unsigned BEEP_DIV   = 25_000_000,
  parameter int unsigned SNOOZE_S   = 300,
  parameter int unsigned TIMEOUT_S  = 60,
  parameter int unsigned MAX_SNOOZE = 3
) (
  input  logic                 masCLK,
  input  logic                 Reset,
  input  logic                 tick_1s,
  input  logic                 match,
  input  logic                 Alarm_ON,
  input  logic                 Snooze_in,
  input  logic                 Stop_in,
  output logic                 Buzzer,
  output logic                 ringing,
  output logic                 snoozed,
  output logic [SNZ_CNT_W-1:0] snooze_cnt
);

  localparam int RS_W = $clog2(TIMEOUT_S + 1);
  localparam int SL_W = $clog2(SNOOZE_S + 1);
  localparam int DV_W = (BEEP_DIV > 1) ? $clog2(BEEP_DIV) : 1;

  localparam logic [RS_W-1:0]      RING_LAST = RS_W'(TIMEOUT_S - 1);
  localparam logic [SL_W-1:0]      SNZ_LOAD  = SL_W'(SNOOZE_S);
  localparam logic [DV_W-1:0]      DIV_LAST  = DV_W'(BEEP_DIV - 1);
  localparam logic [SNZ_CNT_W-1:0] SNZ_MAX   = SNZ_CNT_W'(MAX_SNOOZE);

  alarm_state_e    state;
  logic [RS_W-1:0] ring_sec;
  logic [SL_W-1:0] snz_left;
  logic [DV_W-1:0] div_cnt;
  logic            snz_edge;
  logic            stop_edge;

  edge_rise u_snooze_edge (
    .masCLK (masCLK),
    .Reset  (Reset),
    .level  (Snooze_in),
    .pulse  (snz_edge)
  );

  edge_rise u_stop_edge (
    .masCLK (masCLK),
    .Reset  (Reset),
    .level  (Stop_in),
    .pulse  (stop_edge)
  );

  // Each branch writes the flag outputs for the state it moves to, so they stay registered.
  always_ff @(posedge masCLK) begin
    if (Reset) begin
      state      <= IDLE;
      ring_sec   <= '0;
      snz_left   <= '0;
      div_cnt    <= '0;
      Buzzer     <= 1'b0;
      ringing    <= 1'b0;
      snoozed    <= 1'b0;
      snooze_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Alarm_ON && match) begin
            state    <= RING;
            ringing  <= 1'b1;
            Buzzer   <= 1'b1;
            ring_sec <= '0;
            div_cnt  <= '0;
          end
        end

        RING: begin
          if (!Alarm_ON || stop_edge) begin
            state   <= DONE;
            ringing <= 1'b0;
            Buzzer  <= 1'b0;
          end else if (snz_edge && (snooze_cnt < SNZ_MAX)) begin
            state      <= SNOOZE;
            ringing    <= 1'b0;
            snoozed    <= 1'b1;
            Buzzer     <= 1'b0;
            snooze_cnt <= snooze_cnt + SNZ_CNT_W'(1);
            snz_left   <= SNZ_LOAD;
          end else if (tick_1s && (ring_sec == RING_LAST)) begin
            state   <= DONE;
            ringing <= 1'b0;
            Buzzer  <= 1'b0;
          end else begin
            if (tick_1s) ring_sec <= ring_sec + RS_W'(1);
            if (div_cnt == DIV_LAST) begin
              div_cnt <= '0;
              Buzzer  <= ~Buzzer;
            end else begin
              div_cnt <= div_cnt + DV_W'(1);
            end
          end
        end

        SNOOZE: begin
          if (!Alarm_ON || stop_edge) begin
            state   <= DONE;
            snoozed <= 1'b0;
          end else if (tick_1s) begin
            if (snz_left == SL_W'(1)) begin
              state    <= RING;
              snoozed  <= 1'b0;
              ringing  <= 1'b1;
              Buzzer   <= 1'b1;
              ring_sec <= '0;
              div_cnt  <= '0;
            end else begin
              snz_left <= snz_left - SL_W'(1);
            end
          end
        end

        DONE: begin
          // Holding here until match drops stops a re-trigger within the same minute.
          if (!match) begin
            state      <= IDLE;
            snooze_cnt <= '0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_ringer.sv
// Directed bench for alarm_ringer with small parameters and a 20-cycle tick period.
module tb_alarm_ringer;

  logic       masCLK = 1'b0;
  logic       Reset = 1'b1;
  logic       tick_1s = 1'b0;
  logic       match = 1'b0;
  logic       Alarm_ON = 1'b0;
  logic       Snooze_in = 1'b0;
  logic       Stop_in = 1'b0;
  logic       Buzzer;
  logic       ringing;
  logic       snoozed;
  logic [3:0] snooze_cnt;

  int n_cmp = 0;
  int n_err = 0;

  alarm_ringer #(
    .BEEP_DIV   (4),
    .SNOOZE_S   (5),
    .TIMEOUT_S  (3),
    .MAX_SNOOZE (2)
  ) dut (
    .masCLK     (masCLK),
    .Reset      (Reset),
    .tick_1s    (tick_1s),
    .match      (match),
    .Alarm_ON   (Alarm_ON),
    .Snooze_in  (Snooze_in),
    .Stop_in    (Stop_in),
    .Buzzer     (Buzzer),
    .ringing    (ringing),
    .snoozed    (snoozed),
    .snooze_cnt (snooze_cnt)
  );

  always #5 masCLK = ~masCLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change 1 ns after the edge; outputs are read at the same point.
  task automatic step();
    @(posedge masCLK);
    #1;
  endtask

  // 19 quiet cycles then a one-cycle tick; on return the tick's effect is visible.
  task automatic pulse_tick();
    repeat (19) step();
    tick_1s = 1'b1;
    step();
    tick_1s = 1'b0;
  endtask

  // Press a button (held); on return the press has reached the state register.
  task automatic press_snooze();
    Snooze_in = 1'b1;
    step();
    step();
  endtask

  task automatic press_stop();
    Stop_in = 1'b1;
    step();
    step();
  endtask

  task automatic release_buttons();
    Snooze_in = 1'b0;
    Stop_in   = 1'b0;
    step();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    step();
    step();
    n_cmp++; if (ringing !== 1'b0) begin n_err++; $display("FAIL reset_ringing: got %b want 0", ringing); end
    n_cmp++; if (snoozed !== 1'b0) begin n_err++; $display("FAIL reset_snoozed: got %b want 0", snoozed); end
    n_cmp++; if (Buzzer !== 1'b0) begin n_err++; $display("FAIL reset_buzzer: got %b want 0", Buzzer); end
    n_cmp++; if (snooze_cnt !== 4'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", snooze_cnt); end
    Reset = 1'b0;
    step();
  endtask

  task automatic test_start_beep();
    logic exp_buz;
    Alarm_ON = 1'b1;
    match    = 1'b1;
    step();
    n_cmp++; if (ringing !== 1'b1) begin n_err++; $display("FAIL start_ringing: got %b want 1", ringing); end
    n_cmp++; if (Buzzer !== 1'b1) begin n_err++; $display("FAIL start_buzzer: got %b want 1", Buzzer); end
    for (int i = 1; i < 12; i++) begin
      step();
      exp_buz = ((i % 8) < 4);
      n_cmp++; if (Buzzer !== exp_buz) begin n_err++; $display("FAIL beep_pattern[%0d]: got %b want %b", i, Buzzer, exp_buz); end
    end
  endtask

  task automatic test_timeout();
    pulse_tick();
    pulse_tick();
    n_cmp++; if (ringing !== 1'b1) begin n_err++; $display("FAIL timeout_early: got %b want 1 after 2 ticks", ringing); end
    pulse_tick();
    n_cmp++; if (ringing !== 1'b0) begin n_err++; $display("FAIL timeout_ringing: got %b want 0 after 3 ticks", ringing); end
    n_cmp++; if (Buzzer !== 1'b0) begin n_err++; $display("FAIL timeout_buzzer: got %b want 0", Buzzer); end
    repeat (5) step();
    n_cmp++; if (ringing !== 1'b0) begin n_err++; $display("FAIL timeout_guard: got %b want 0 with match held", ringing); end
    match = 1'b0;
    step();
    match = 1'b1;
    step();
    n_cmp++; if (ringing !== 1'b1) begin n_err++; $display("FAIL timeout_rering: got %b want 1", ringing); end
    n_cmp++; if (Buzzer !== 1'b1) begin n_err++; $display("FAIL timeout_rering_buz: got %b want 1", Buzzer); end
  endtask

  task automatic test_snooze_limit();
    Snooze_in = 1'b1;
    step();
    n_cmp++; if (ringing !== 1'b1) begin n_err++; $display("FAIL snooze_latency: got %b want 1 one cycle after press", ringing); end
    step();
    n_cmp++; if (snoozed !== 1'b1) begin n_err++; $display("FAIL snooze1_snoozed: got %b want 1", snoozed); end
    n_cmp++; if (ringing !== 1'b0) begin n_err++; $display("FAIL snooze1_ringing: got %b want 0", ringing); end
    n_cmp++; if (snooze_cnt !== 4'd1) begin n_err++; $display("FAIL snooze1_cnt: got %0d want 1", snooze_cnt); end
    n_cmp++; if (Buzzer !== 1'b0) begin n_err++; $display("FAIL snooze1_buzzer: got %b want 0", Buzzer); end
    release_buttons();
    press_snooze();
    step();
    n_cmp++; if (snooze_cnt !== 4'd1) begin n_err++; $display("FAIL snooze_in_snooze: got %0d want 1", snooze_cnt); end
    release_buttons();
    repeat (4) pulse_tick();
    n_cmp++; if (snoozed !== 1'b1) begin n_err++; $display("FAIL snooze_early: got %b want 1 after 4 ticks", snoozed); end
    pulse_tick();
    n_cmp++; if (ringing !== 1'b1) begin n_err++; $display("FAIL snooze_expire: got %b want 1 after 5 ticks", ringing); end
    n_cmp++; if (snoozed !== 1'b0) begin n_err++; $display("FAIL snooze_expire_snz: got %b want 0", snoozed); end
    press_snooze();
    n_cmp++; if (snooze_cnt !== 4'd2) begin n_err++; $display("FAIL snooze2_cnt: got %0d want 2", snooze_cnt); end
    release_buttons();
    repeat (5) pulse_tick();
    n_cmp++; if (ringing !== 1'b1) begin n_err++; $display("FAIL snooze2_expire: got %b want 1", ringing); end
    press_snooze();
    step();
    n_cmp++; if (ringing !== 1'b1) begin n_err++; $display("FAIL snooze3_ignored: got %b want 1", ringing); end
    n_cmp++; if (snooze_cnt !== 4'd2) begin n_err++; $display("FAIL snooze3_cnt: got %0d want 2", snooze_cnt); end
    release_buttons();
    press_stop();
    n_cmp++; if (ringing !== 1'b0) begin n_err++; $display("FAIL stop_in_ring: got %b want 0", ringing); end
    release_buttons();
    match = 1'b0;
    step();
    n_cmp++; if (snooze_cnt !== 4'd0) begin n_err++; $display("FAIL done_clear_cnt: got %0d want 0", snooze_cnt); end
  endtask

  task automatic test_stop_guard();
    match = 1'b1;
    step();
    press_snooze();
    release_buttons();
    n_cmp++; if (snoozed !== 1'b1) begin n_err++; $display("FAIL guard_snoozed: got %b want 1", snoozed); end
    press_stop();
    n_cmp++; if (snoozed !== 1'b0) begin n_err++; $display("FAIL guard_stop_snz: got %b want 0", snoozed); end
    n_cmp++; if (ringing !== 1'b0) begin n_err++; $display("FAIL guard_stop_ring: got %b want 0", ringing); end
    release_buttons();
    repeat (30) step();
    n_cmp++; if (ringing !== 1'b0) begin n_err++; $display("FAIL guard_no_rering: got %b want 0", ringing); end
    n_cmp++; if (snooze_cnt !== 4'd1) begin n_err++; $display("FAIL guard_cnt_held: got %0d want 1", snooze_cnt); end
    match = 1'b0;
    step();
    n_cmp++; if (snooze_cnt !== 4'd0) begin n_err++; $display("FAIL guard_cnt_clear: got %0d want 0", snooze_cnt); end
  endtask

  task automatic test_priority();
    match = 1'b1;
    step();
    Snooze_in = 1'b1;
    Stop_in   = 1'b1;
    step();
    step();
    n_cmp++; if (ringing !== 1'b0) begin n_err++; $display("FAIL prio_ring: got %b want 0", ringing); end
    n_cmp++; if (snoozed !== 1'b0) begin n_err++; $display("FAIL prio_snz: got %b want 0", snoozed); end
    n_cmp++; if (snooze_cnt !== 4'd0) begin n_err++; $display("FAIL prio_cnt: got %0d want 0", snooze_cnt); end
    release_buttons();
    match = 1'b0;
    step();
    match = 1'b1;
    step();
    n_cmp++; if (Buzzer !== 1'b1) begin n_err++; $display("FAIL disable_pre_buz: got %b want 1", Buzzer); end
    Alarm_ON = 1'b0;
    step();
    n_cmp++; if (ringing !== 1'b0) begin n_err++; $display("FAIL disable_ring: got %b want 0", ringing); end
    n_cmp++; if (Buzzer !== 1'b0) begin n_err++; $display("FAIL disable_buz: got %b want 0", Buzzer); end
    match = 1'b0;
    step();
    Alarm_ON = 1'b1;
    match    = 1'b1;
    step();
    pulse_tick();
    pulse_tick();
    // Snooze edge pulse lands on the same cycle as the timeout tick.
    repeat (18) step();
    Snooze_in = 1'b1;
    step();
    tick_1s = 1'b1;
    step();
    tick_1s = 1'b0;
    n_cmp++; if (snoozed !== 1'b1) begin n_err++; $display("FAIL snooze_vs_timeout: got %b want 1", snoozed); end
    n_cmp++; if (snooze_cnt !== 4'd1) begin n_err++; $display("FAIL snooze_vs_timeout_cnt: got %0d want 1", snooze_cnt); end
    release_buttons();
    press_stop();
    release_buttons();
    match = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_ring();
    match = 1'b1;
    step();
    press_snooze();
    release_buttons();
    repeat (5) pulse_tick();
    n_cmp++; if (ringing !== 1'b1 || snooze_cnt !== 4'd1) begin n_err++; $display("FAIL rst_setup: got ring %b cnt %0d want 1/1", ringing, snooze_cnt); end
    Reset = 1'b1;
    step();
    n_cmp++; if ({Buzzer, ringing, snoozed, snooze_cnt} !== 7'd0) begin n_err++; $display("FAIL rst_mid_outputs: got buz %b ring %b snz %b cnt %0d want all 0", Buzzer, ringing, snoozed, snooze_cnt); end
    Reset = 1'b0;
    step();
    n_cmp++; if (ringing !== 1'b1) begin n_err++; $display("FAIL rst_rering: got %b want 1", ringing); end
    n_cmp++; if (Buzzer !== 1'b1) begin n_err++; $display("FAIL rst_rering_buz: got %b want 1", Buzzer); end
    n_cmp++; if (snooze_cnt !== 4'd0) begin n_err++; $display("FAIL rst_rering_cnt: got %0d want 0", snooze_cnt); end
  endtask

  initial begin
    test_reset();
    test_start_beep();
    test_timeout();
    test_snooze_limit();
    test_stop_guard();
    test_priority();
    test_reset_mid_ring();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
